// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: runs one req/ack data-bus transaction per
// aligned load/store and returns the lane-selected, extended load result.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  memlen_i,
    input  logic [1:0]  memwe_i,
    input  logic [32:0] aluout_i,
    input  logic [32:0] rd2_i,
    output logic [32:0] memrd_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        buserr_o,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         len_q, len_d;
    logic [1:0]         addr_lo_q, addr_lo_d;
    logic [32:0]        memrd_q, memrd_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               buserr_q, buserr_d;

    logic               access_c;
    logic               misalign_c;
    logic [3:0]         be_c;
    logic [31:0]        wdata_c;
    logic               unused_bits;

    assign unused_bits = ^{memwe_i[1], aluout_i[32], rd2_i[32]};

    // Select the addressed lane, then sign- or zero-extend it.
    function automatic logic [31:0] fmt_load(input logic [31:0] d,
                                             input logic [2:0]  len,
                                             input logic [1:0]  a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        case (len[1:0])
            2'd1:    r = len[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'd2:    r = len[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = d;
        endcase
        return r;
    endfunction

    assign access_c   = (memlen_i[1:0] != 2'd0);
    assign misalign_c = ((memlen_i[1:0] == 2'd2) && aluout_i[0]) ||
                        ((memlen_i[1:0] == 2'd3) && (aluout_i[1:0] != 2'd0));

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = rd2_i[31:0];
        case (memlen_i[1:0])
            2'd1: begin
                be_c    = 4'b0001 << aluout_i[1:0];
                wdata_c = {4{rd2_i[7:0]}};
            end
            2'd2: begin
                be_c    = 4'b0011 << aluout_i[1:0];
                wdata_c = {2{rd2_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign stall_o    = (state_q == BUSY) ||
                        ((state_q == IDLE) && access_c && !misalign_c);
    assign misalign_o = misalign_c;

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        addr_lo_d = addr_lo_q;
        memrd_d   = memrd_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        buserr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (access_c && misalign_c) begin
                    memrd_d = '0;
                end else if (access_c) begin
                    req_d     = 1'b1;
                    we_d      = memwe_i[0];
                    addr_d    = {aluout_i[31:2], 2'b00};
                    be_d      = be_c;
                    wdata_d   = wdata_c;
                    len_d     = memlen_i;
                    addr_lo_d = aluout_i[1:0];
                    cnt_d     = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (bus_ack) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) begin
                        memrd_d = {1'b0, fmt_load(bus_rdata, len_q, addr_lo_q)};
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    req_d    = 1'b0;
                    memrd_d  = '0;
                    buserr_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            addr_lo_q <= '0;
            memrd_q   <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            buserr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            addr_lo_q <= addr_lo_d;
            memrd_q   <= memrd_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            buserr_q  <= buserr_d;
        end
    end

    assign memrd_o   = memrd_q;
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign buserr_o  = buserr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: transaction-level reference model with a
// per-cycle compare process, directed pins plus randomized traffic.
module tb_mem_access_stage;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst;
    logic [2:0]  memlen_i;
    logic [1:0]  memwe_i;
    logic [32:0] aluout_i;
    logic [32:0] rd2_i;
    logic [32:0] memrd_o;
    logic        stall_o;
    logic        misalign_o;
    logic        buserr_o;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .memlen_i   (memlen_i),
        .memwe_i    (memwe_i),
        .aluout_i   (aluout_i),
        .rd2_i      (rd2_i),
        .memrd_o    (memrd_o),
        .stall_o    (stall_o),
        .misalign_o (misalign_o),
        .buserr_o   (buserr_o),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic        chk_en;
    logic [32:0] model_memrd;
    logic        exp_stall, exp_mis, exp_req, exp_buserr, exp_we;
    logic [32:0] exp_memrd;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;

    int          req_cycles = 0;
    int          stall_cycles = 0;
    int          buserr_cnt = 0;
    logic        last_we;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_be;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [2:0] len,
                                             input logic [31:0] addr);
        int unsigned v;
        int unsigned sh;
        v = d;
        if (len[1:0] == 2'd1) begin
            sh = 8 * int'(addr[1:0]);
            v  = (d >> sh) & 32'hFF;
            if (!len[2] && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (len[1:0] == 2'd2) begin
            sh = 16 * int'(addr[1]);
            v  = (d >> sh) & 32'hFFFF;
            if (!len[2] && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] len, input logic [31:0] addr);
        int unsigned n;
        n = 15;
        if (len[1:0] == 2'd1) n = 1 << addr[1:0];
        if (len[1:0] == 2'd2) n = 3 << addr[1:0];
        return 4'(n);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] len, input logic [31:0] d);
        if (len[1:0] == 2'd1) return (d & 32'hFF) * 32'h0101_0101;
        if (len[1:0] == 2'd2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    // Per-cycle comparison against the model's expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 33'(stall_o), 33'(exp_stall));
            check("misalign", 33'(misalign_o), 33'(exp_mis));
            check("bus_req", 33'(bus_req), 33'(exp_req));
            check("buserr", 33'(buserr_o), 33'(exp_buserr));
            check("memrd", memrd_o, exp_memrd);
            if (exp_req) begin
                check("bus_we", 33'(bus_we), 33'(exp_we));
                check("bus_addr", 33'(bus_addr), 33'(exp_addr));
                check("bus_be", 33'(bus_be), 33'(exp_be));
                check("bus_wdata", 33'(bus_wdata), 33'(exp_wdata));
            end
        end
    end

    always @(negedge clk) begin
        if (bus_req) begin
            req_cycles++;
            last_we    = bus_we;
            last_addr  = bus_addr;
            last_be    = bus_be;
            last_wdata = bus_wdata;
        end
        if (stall_o) stall_cycles++;
        if (buserr_o) buserr_cnt++;
    end

    // One instruction through the stage; ackc = BUSY cycle carrying ack, 0 = never.
    task automatic run_op(input logic [2:0] len, input logic we, input logic [31:0] addr,
                          input logic [31:0] data, input int ackc, input logic [31:0] rdata);
        logic acc, mis, tmo;
        @(posedge clk); #1;
        memlen_i  = len;
        memwe_i   = {1'($urandom), we};
        aluout_i  = {1'($urandom), addr};
        rd2_i     = {1'($urandom), data};
        bus_ack   = 1'($urandom);
        bus_rdata = $urandom;
        acc = (len[1:0] != 2'd0);
        mis = ((len[1:0] == 2'd2) && addr[0]) || ((len[1:0] == 2'd3) && (addr[1:0] != 2'd0));
        exp_stall  = acc && !mis;
        exp_mis    = mis;
        exp_req    = 1'b0;
        exp_buserr = 1'b0;
        exp_memrd  = model_memrd;
        if (!acc) return;
        if (mis) begin
            model_memrd = '0;
            return;
        end
        exp_we    = we;
        exp_addr  = addr & 32'hFFFF_FFFC;
        exp_be    = ref_be(len, addr);
        exp_wdata = ref_wdata(len, data);
        tmo = 1'b1;
        for (int c = 1; c <= int'(TO); c++) begin
            @(posedge clk); #1;
            bus_ack   = (c == ackc);
            bus_rdata = (c == ackc) ? rdata : $urandom;
            exp_req   = 1'b1;
            exp_stall = 1'b1;
            exp_mis   = 1'b0;
            if (c == ackc) begin
                tmo = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        bus_ack   = 1'($urandom);
        bus_rdata = $urandom;
        if (tmo) model_memrd = '0;
        else if (!we) model_memrd = {1'b0, ref_load(rdata, len, addr)};
        exp_req    = 1'b0;
        exp_stall  = 1'b0;
        exp_mis    = 1'b0;
        exp_buserr = tmo;
        exp_memrd  = model_memrd;
    endtask

    initial begin
        int s0, r0, b0;
        clk = 0; rst = 0; chk_en = 0; model_memrd = '0;
        memlen_i = '0; memwe_i = '0; aluout_i = '0; rd2_i = '0;
        bus_rdata = '0; bus_ack = 0;
        exp_stall = 0; exp_mis = 0; exp_req = 0; exp_buserr = 0; exp_memrd = '0;
        exp_we = 0; exp_addr = '0; exp_be = '0; exp_wdata = '0;

        #12;
        check("rst_memrd", memrd_o, 33'h0);
        check("rst_req", 33'(bus_req), 33'h0);
        check("rst_be", 33'(bus_be), 33'h0);
        check("rst_addr", 33'(bus_addr), 33'h0);
        check("rst_wdata", 33'(bus_wdata), 33'h0);
        check("rst_buserr", 33'(buserr_o), 33'h0);
        check("rst_stall_idle", 33'(stall_o), 33'h0);
        memlen_i = 3'b011; #1;
        check("rst_stall_access", 33'(stall_o), 33'h1);
        memlen_i = '0;
        @(negedge clk); rst = 1; chk_en = 1;

        s0 = stall_cycles;
        run_op(3'b011, 0, 32'h100, 32'h0, 1, 32'hDEAD_BEEF);
        @(negedge clk); #1;
        check("lit_word_memrd", memrd_o, 33'h0_DEAD_BEEF);
        check("lit_word_stall", 33'(stall_cycles - s0), 33'd2);
        check("lit_word_addr", 33'(last_addr), 33'h100);
        check("lit_word_be", 33'(last_be), 33'hF);

        run_op(3'b001, 0, 32'h203, 32'h0, 1, 32'h8012_3456);
        @(negedge clk); #1;
        check("lit_sbyte_memrd", memrd_o, 33'h0_FFFF_FF80);
        check("lit_sbyte_be", 33'(last_be), 33'h8);
        run_op(3'b101, 0, 32'h203, 32'h0, 1, 32'h8012_3456);
        @(negedge clk); #1;
        check("lit_zbyte_memrd", memrd_o, 33'h0_0000_0080);

        run_op(3'b010, 1, 32'h302, 32'h0000_ABCD, 2, 32'h0);
        @(negedge clk); #1;
        check("lit_hst_we", 33'(last_we), 33'h1);
        check("lit_hst_addr", 33'(last_addr), 33'h300);
        check("lit_hst_be", 33'(last_be), 33'hC);
        check("lit_hst_wdata", 33'(last_wdata), 33'h0_ABCD_ABCD);
        check("lit_hst_memrd", memrd_o, 33'h0_0000_0080);

        r0 = req_cycles;
        run_op(3'b010, 0, 32'h301, 32'h0, 1, 32'h0);
        @(negedge clk); #1;
        check("lit_mis_flag", 33'(misalign_o), 33'h1);
        check("lit_mis_stall", 33'(stall_o), 33'h0);
        run_op(3'b000, 0, 32'h0, 32'h0, 0, 32'h0);
        @(negedge clk); #1;
        check("lit_mis_memrd", memrd_o, 33'h0);
        check("lit_mis_noreq", 33'(req_cycles - r0), 33'h0);

        run_op(3'b011, 0, 32'h104, 32'h0, 3, 32'h1234_5678);
        r0 = req_cycles; b0 = buserr_cnt;
        run_op(3'b011, 0, 32'h500, 32'h0, 0, 32'h0);
        @(negedge clk); #1;
        check("lit_to_reqcyc", 33'(req_cycles - r0), 33'd4);
        check("lit_to_buserr", 33'(buserr_cnt - b0), 33'd1);
        check("lit_to_memrd", memrd_o, 33'h0);
        check("lit_to_stall", 33'(stall_o), 33'h0);

        // Reset asserted during the second BUSY cycle.
        chk_en = 0;
        @(posedge clk); #1;
        memlen_i = 3'b011; memwe_i = 2'b00; aluout_i = 33'h400; bus_ack = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_mid_pre_req", 33'(bus_req), 33'h1);
        #2; rst = 0; memlen_i = '0; #1;
        check("rst_mid_req", 33'(bus_req), 33'h0);
        check("rst_mid_stall", 33'(stall_o), 33'h0);
        check("rst_mid_memrd", memrd_o, 33'h0);
        @(posedge clk); #1; rst = 1; model_memrd = '0;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_req", 33'(bus_req), 33'h0);
            check("post_rst_stall", 33'(stall_o), 33'h0);
        end
        #1; chk_en = 1;

        repeat (300) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a = a & 32'h0000_0FFF;
            run_op(3'($urandom), 1'($urandom), a, $urandom,
                   int'($urandom_range(0, TO + 1)), $urandom);
        end

        @(negedge clk); #1; chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
